// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU operation codes and the
// control bundle carried from decode into the execute stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // rt is read as a source operand only by R-type, sw and beq; for lw and
  // addi it is the destination and must not trigger a load-use stall.
  function automatic logic rt_is_source(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

endpackage

// File: rtl/id_ex_stage_main_decoder.sv
// Main control decoder: maps the opcode to the control bundle and flags
// any opcode outside the supported subset as illegal.
module main_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       illegal
);

  // Opcode lookup; unsupported opcodes produce no control and raise illegal.
  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      OP_LW: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_OP_SUB;
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register of the 5-stage MIPS pipeline.
// Drives register-file read addresses, decodes control, detects load-use
// hazards (inserting one bubble) and honours branch flush and downstream hold.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_id_valid,
  input  logic [DW-1:0] if_id_instr,
  input  logic [DW-1:0] if_id_pc4,
  output logic [AW-1:0] readRegister1,
  output logic [AW-1:0] readRegister2,
  input  logic [DW-1:0] readData1,
  input  logic [DW-1:0] readData2,
  input  logic          flush,
  input  logic          hold_in,
  output logic          stall_out,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_alu_src,
  output logic          ex_branch,
  output logic          ex_illegal,
  output logic [1:0]    ex_alu_op,
  output logic [AW-1:0] ex_rs,
  output logic [AW-1:0] ex_rt,
  output logic [AW-1:0] ex_dst,
  output logic [DW-1:0] ex_rd1,
  output logic [DW-1:0] ex_rd2,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc4,
  output logic [5:0]    ex_funct
);

  // ---- ID stage (p0): field extraction and decode ----
  logic [5:0]           opcode_p0;
  logic [AW-1:0]        rs_p0;
  logic [AW-1:0]        rt_p0;
  logic [AW-1:0]        rd_p0;
  logic [AW-1:0]        dst_p0;
  logic signed [DW-1:0] imm_p0;
  ctrl_t                dec_ctrl_p0;
  logic                 dec_illegal_p0;
  logic                 rt_src_p0;
  logic                 haz_p0;

  assign opcode_p0 = if_id_instr[31:26];
  assign rs_p0     = if_id_instr[25:21];
  assign rt_p0     = if_id_instr[20:16];
  assign rd_p0     = if_id_instr[15:11];
  assign dst_p0    = (opcode_p0 == OP_RTYPE) ? rd_p0 : rt_p0;
  assign imm_p0    = {{(DW-16){if_id_instr[15]}}, if_id_instr[15:0]};
  assign rt_src_p0 = rt_is_source(opcode_p0);

  assign readRegister1 = rs_p0;
  assign readRegister2 = rt_p0;

  main_decoder u_main_decoder (
    .opcode  (opcode_p0),
    .ctrl    (dec_ctrl_p0),
    .illegal (dec_illegal_p0)
  );

  // ---- ID/EX register (p1) ----
  logic                 vld_p1;
  ctrl_t                ctrl_p1;
  logic                 illegal_p1;
  logic [AW-1:0]        rs_p1;
  logic [AW-1:0]        rt_p1;
  logic [AW-1:0]        dst_p1;
  logic [DW-1:0]        rd1_p1;
  logic [DW-1:0]        rd2_p1;
  logic signed [DW-1:0] imm_p1;
  logic [DW-1:0]        pc4_p1;
  logic [5:0]           funct_p1;

  // Load-use: a load in EX whose target ($0 excluded) is read by the
  // instruction in ID cannot forward in time, so ID waits one cycle.
  assign haz_p0 = vld_p1 & ctrl_p1.mem_read & (rt_p1 != '0) & if_id_valid &
                  ((rt_p1 == rs_p0) | (rt_src_p0 & (rt_p1 == rt_p0)));

  assign stall_out = hold_in | (haz_p0 & ~flush);

  // Pipeline register update: reset > flush > hold > bubble > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      ctrl_p1    <= CTRL_NOP;
      illegal_p1 <= 1'b0;
      rs_p1      <= '0;
      rt_p1      <= '0;
      dst_p1     <= '0;
      rd1_p1     <= '0;
      rd2_p1     <= '0;
      imm_p1     <= '0;
      pc4_p1     <= '0;
      funct_p1   <= '0;
    end else if (flush) begin
      vld_p1     <= 1'b0;
      ctrl_p1    <= CTRL_NOP;
      illegal_p1 <= 1'b0;
    end else if (!hold_in) begin
      if (haz_p0) begin
        vld_p1     <= 1'b0;
        ctrl_p1    <= CTRL_NOP;
        illegal_p1 <= 1'b0;
      end else begin
        vld_p1     <= if_id_valid;
        ctrl_p1    <= if_id_valid ? dec_ctrl_p0 : CTRL_NOP;
        illegal_p1 <= if_id_valid & dec_illegal_p0;
        rs_p1      <= rs_p0;
        rt_p1      <= rt_p0;
        dst_p1     <= dst_p0;
        rd1_p1     <= readData1;
        rd2_p1     <= readData2;
        imm_p1     <= imm_p0;
        pc4_p1     <= if_id_pc4;
        funct_p1   <= if_id_instr[5:0];
      end
    end
  end

  // ---- EX-facing outputs ----
  assign ex_valid     = vld_p1;
  assign ex_reg_write = ctrl_p1.reg_write;
  assign ex_mem_read  = ctrl_p1.mem_read;
  assign ex_mem_write = ctrl_p1.mem_write;
  assign ex_alu_src   = ctrl_p1.alu_src;
  assign ex_branch    = ctrl_p1.branch;
  assign ex_alu_op    = ctrl_p1.alu_op;
  assign ex_illegal   = illegal_p1;
  assign ex_rs        = rs_p1;
  assign ex_rt        = rt_p1;
  assign ex_dst       = dst_p1;
  assign ex_rd1       = rd1_p1;
  assign ex_rd2       = rd2_p1;
  assign ex_imm       = imm_p1;
  assign ex_pc4       = pc4_p1;
  assign ex_funct     = funct_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_id_valid = 1'b0;
  logic [31:0] if_id_instr = '0;
  logic [31:0] if_id_pc4 = '0;
  logic        flush = 1'b0;
  logic        hold_in = 1'b0;
  logic [4:0]  readRegister1, readRegister2;
  logic [31:0] readData1, readData2;
  logic        stall_out;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_alu_src, ex_branch, ex_illegal;
  logic [1:0]  ex_alu_op;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
  logic [5:0]  ex_funct;

  logic [31:0] regs [32];
  assign readData1 = regs[readRegister1];
  assign readData2 = regs[readRegister2];

  id_ex_stage #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .readRegister1(readRegister1), .readRegister2(readRegister2),
    .readData1(readData1), .readData2(readData2), .flush(flush), .hold_in(hold_in),
    .stall_out(stall_out), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal), .ex_alu_op(ex_alu_op),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_funct(ex_funct)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  bit stall_seen;
  bit model_stall_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected ID/EX contents. c = {reg_write, mem_read, mem_write, alu_src, branch, alu_op[1:0], illegal}
  typedef struct packed {
    bit        valid;
    bit [7:0]  c;
    bit [4:0]  rs, rt, dst;
    bit [31:0] rd1, rd2, imm, pc4;
    bit [5:0]  funct;
  } exp_t;

  exp_t m = '0;

  function automatic bit [7:0] decode_tbl(input bit [5:0] op);
    case (op)
      6'h00:   return 8'b1000_0100;  // R-type
      6'h23:   return 8'b1101_0000;  // lw
      6'h2B:   return 8'b0011_0000;  // sw
      6'h04:   return 8'b0000_1010;  // beq
      6'h08:   return 8'b1001_0000;  // addi
      default: return 8'b0000_0001;  // illegal
    endcase
  endfunction

  function automatic bit model_haz();
    bit [5:0] op = if_id_instr[31:26];
    bit [4:0] rs = if_id_instr[25:21];
    bit [4:0] rt = if_id_instr[20:16];
    bit rt_read = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    bit ex_is_load = m.valid && m.c[6];
    return ex_is_load && (m.rt != 0) && if_id_valid &&
           ((m.rt == rs) || (rt_read && (m.rt == rt)));
  endfunction

  function automatic bit model_stall();
    return hold_in || (model_haz() && !flush);
  endfunction

  // Reference model advances on every rising edge from the applied inputs.
  always @(posedge clk) begin
    exp_t n;
    n = m;
    if (rst) begin
      n = '0;
    end else if (flush) begin
      n.valid = 1'b0;
      n.c = '0;
    end else if (hold_in) begin
      n = m;
    end else if (model_haz()) begin
      n.valid = 1'b0;
      n.c = '0;
    end else begin
      n.valid = if_id_valid;
      n.c     = if_id_valid ? decode_tbl(if_id_instr[31:26]) : 8'h00;
      n.rs    = if_id_instr[25:21];
      n.rt    = if_id_instr[20:16];
      n.dst   = (if_id_instr[31:26] == 6'h00) ? if_id_instr[15:11] : if_id_instr[20:16];
      n.rd1   = regs[if_id_instr[25:21]];
      n.rd2   = regs[if_id_instr[20:16]];
      n.imm   = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
      n.pc4   = if_id_pc4;
      n.funct = if_id_instr[5:0];
    end
    m <= n;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("readRegister1", 32'(readRegister1), 32'(if_id_instr[25:21]));
      check("readRegister2", 32'(readRegister2), 32'(if_id_instr[20:16]));
      check("stall_out", 32'(stall_out), 32'(model_stall()));
      check("ex_valid", 32'(ex_valid), 32'(m.valid));
      check("ex_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src,
                            ex_branch, ex_alu_op, ex_illegal}), 32'(m.c));
      if (m.valid) begin
        check("ex_regnums", 32'({ex_rs, ex_rt, ex_dst}), 32'({m.rs, m.rt, m.dst}));
        check("ex_rd1", ex_rd1, m.rd1);
        check("ex_rd2", ex_rd2, m.rd2);
        check("ex_imm", ex_imm, m.imm);
        check("ex_pc4", ex_pc4, m.pc4);
        check("ex_funct", 32'(ex_funct), 32'(m.funct));
      end
    end
  end

  task automatic cyc(input bit r, input bit v, input bit fl, input bit hd,
                     input logic [31:0] ins, input logic [31:0] pc);
    rst = r; if_id_valid = v; flush = fl; hold_in = hd;
    if_id_instr = ins; if_id_pc4 = pc;
    #1;
    stall_seen = stall_out;
    model_stall_seen = model_stall();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [31:0] w;
    case ($urandom_range(0, 5))
      0: op = 6'h00;
      1: op = 6'h23;
      2: op = 6'h2B;
      3: op = 6'h04;
      4: op = 6'h08;
      default: op = 6'($urandom);
    endcase
    w = $urandom;
    w[31:26] = op;
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    bit keep;
    logic [31:0] ins;
    logic [31:0] pc;
    bit v;
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : $urandom;
    regs[1] = 32'd5;
    regs[2] = 32'd7;

    // Reset held for two cycles with a valid instruction present.
    cyc(1, 1, 0, 0, 32'h00221820, 32'h0000_0104);
    chk_en = 1'b1;
    cyc(1, 1, 0, 0, 32'h00221820, 32'h0000_0104);
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src,
                           ex_branch, ex_alu_op, ex_illegal}), 32'd0);
    check("rst_regnums", 32'({ex_rs, ex_rt, ex_dst, ex_funct}), 32'd0);
    check("rst_rd1", ex_rd1, 32'd0);
    check("rst_imm_pc4", ex_imm | ex_pc4 | ex_rd2, 32'd0);

    // add $3,$1,$2
    cyc(0, 1, 0, 0, 32'h00221820, 32'h0000_0104);
    check("rst_stall", 32'(stall_seen), 32'd0);
    check("add_valid_rw", 32'({ex_valid, ex_reg_write}), 32'b11);
    check("add_alu_op", 32'(ex_alu_op), 32'b10);
    check("add_dst", 32'(ex_dst), 32'd3);
    check("add_rd1_rd2", {ex_rd1[15:0], ex_rd2[15:0]}, {16'd5, 16'd7});
    check("add_funct", 32'(ex_funct), 32'h20);

    // lw $4,-4($1)
    cyc(0, 1, 0, 0, 32'h8C24FFFC, 32'h0000_0108);
    check("lw_mr_as", 32'({ex_mem_read, ex_alu_src}), 32'b11);
    check("lw_dst", 32'(ex_dst), 32'd4);
    check("lw_imm", ex_imm, 32'hFFFFFFFC);

    // Load-use: lw $4,0($1) then add $5,$4,$2
    cyc(0, 1, 0, 0, 32'h8C240000, 32'h0000_010C);
    check("lu_lw_nostall", 32'(stall_seen), 32'd0);
    cyc(0, 1, 0, 0, 32'h00822820, 32'h0000_0110);
    check("lu_stall", 32'(stall_seen), 32'd1);
    check("lu_bubble", 32'({ex_valid, ex_reg_write}), 32'd0);
    cyc(0, 1, 0, 0, 32'h00822820, 32'h0000_0110);
    check("lu_stall_once", 32'(stall_seen), 32'd0);
    check("lu_add_loaded", 32'({ex_valid, ex_rs}), 32'({1'b1, 5'd4}));

    // lw $0 never stalls the reader of $0
    cyc(0, 1, 0, 0, 32'h8C200000, 32'h0000_0114);
    cyc(0, 1, 0, 0, 32'h00022820, 32'h0000_0118);
    check("r0_nostall", 32'(stall_seen), 32'd0);
    check("r0_loaded", 32'({ex_valid, ex_rs}), 32'({1'b1, 5'd0}));

    // Flush overrides hold
    cyc(0, 1, 1, 1, 32'h00221820, 32'h0000_011C);
    check("flush_stall", 32'(stall_seen), 32'd1);
    check("flush_ctrl", 32'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
                             ex_alu_src, ex_branch, ex_alu_op, ex_illegal}), 32'd0);

    // Illegal opcode
    cyc(0, 1, 0, 0, 32'hFC000000, 32'h0000_0120);
    check("ill_valid_flag", 32'({ex_valid, ex_illegal}), 32'b11);
    check("ill_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src,
                           ex_branch, ex_alu_op}), 32'd0);

    // Reset arriving during a load-use stall
    cyc(0, 1, 0, 0, 32'h8C240000, 32'h0000_0124);
    cyc(1, 1, 0, 0, 32'h00822820, 32'h0000_0128);
    check("rst_mid_stall_before", 32'(stall_seen), 32'd1);
    cyc(0, 1, 0, 0, 32'h00822820, 32'h0000_0128);
    check("rst_mid_stall_after", 32'(stall_seen), 32'd0);
    check("rst_mid_loaded", 32'(ex_valid), 32'd1);

    // Randomized traffic with an upstream IF/ID that holds while stalled.
    ins = rand_instr();
    pc = 32'h0000_0200;
    v = 1'b1;
    keep = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (!keep) begin
        ins = rand_instr();
        pc = pc + 32'd4;
        v = ($urandom_range(0, 99) < 85);
      end
      if ($urandom_range(0, 99) < 5) regs[$urandom_range(1, 31)] = $urandom;
      cyc($urandom_range(0, 99) < 2, v, $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 12, ins, pc);
      keep = model_stall_seen;
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register of the 5-stage MIPS pipeline.
- Takes the IF/ID instruction and PC+4, and drives the register-file read addresses.
- Captures the register-file read data, sign-extended immediate and decoded control into the ID/EX register.
- Detects load-use hazards and inserts bubbles; honours branch flush and downstream hold.

Parameters:
- DW, 32, datapath width (instruction, PC, register data)
- AW, 5, register address width

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- if_id_valid  in  1  IF/ID holds a real instruction
- if_id_instr  in  DW  instruction word
- if_id_pc4  in  DW  PC+4 of that instruction
- readRegister1  out  AW  instr[25:21] (rs), combinational to register file
- readRegister2  out  AW  instr[20:16] (rt), combinational to register file
- readData1  in  DW  rs data from register file
- readData2  in  DW  rt data from register file
- flush  in  1  branch/jump taken, kill ID contents
- hold_in  in  1  downstream stall, freeze ID/EX
- stall_out  out  1  freeze PC and IF/ID this cycle
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_illegal  out  1 each  registered control
- ex_alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- ex_rs, ex_rt, ex_dst  out  AW each  registered register numbers; dst = rd for R-type, rt otherwise
- ex_rd1, ex_rd2, ex_imm, ex_pc4  out  DW each  registered operands; imm = sign-extended instr[15:0]
- ex_funct  out  6  instr[5:0]

Behaviour:
- Reset: every ex_* output is 0, including ex_valid and all control bits. stall_out is 0 after reset (ex_mem_read=0).
- Latency: 1 cycle. An instruction present at posedge N appears on ex_* after edge N.
- Decode by opcode instr[31:26]:
  - 000000 R-type: reg_write=1, alu_op=10, alu_src=0, dst=rd.
  - 100011 lw: reg_write=1, mem_read=1, alu_src=1, alu_op=00.
  - 101011 sw: mem_write=1, alu_src=1, alu_op=00.
  - 000100 beq: branch=1, alu_op=01.
  - 001000 addi: reg_write=1, alu_src=1, alu_op=00.
  - Other opcodes: all control 0, ex_illegal=1, ex_valid=1.
- Control bits are forced to 0 whenever the captured ex_valid=0.
- rt is a source for R-type, sw and beq only.
- Load-use hazard (combinational), haz = ex_valid & ex_mem_read & ex_rt!=0 & if_id_valid & (ex_rt==rs | (rt is source & ex_rt==rt)).
- stall_out = hold_in | (haz & !flush).
- Priority each posedge, highest first:
  - rst: clear all.
  - flush: ex_valid and all control cleared, data fields don't-care. Flush overrides hold_in.
  - hold_in: all ex_* registers keep their value.
  - haz: bubble inserted (ex_valid=0, control 0); the IF/ID instruction is retained upstream via stall_out.
  - Otherwise: load decoded fields, ex_valid=if_id_valid.
- A hazard bubble lasts exactly one cycle. The next cycle the lw has left EX and the dependent instruction loads.
- if_id_valid=0 with no other event: loads a bubble.
- No write-back bypass needed. The register file writes on negedge, so readData reflects same-cycle WB writes.
- Reset mid-stall: stall_out drops on the cycle after rst is sampled.
- Register $0 never causes a hazard.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - ALU_OP_ADD/SUB/FUNCT;
  - a packed control-bundle typedef (reg_write, mem_read, mem_write, alu_src, branch, alu_op).
- One natural sub-module, main_decoder: combinational, opcode in, control bundle and illegal flag out.
- Hazard logic and the pipeline register stay in id_ex_stage.

Test Plan:
- Reset: rst=1 for 2 cycles with a valid instruction present -> all ex_* = 0, stall_out=0.
- R-type pass-through: add $3,$1,$2 (0x00221820), readData1=5, readData2=7 -> next cycle ex_valid=1, ex_reg_write=1, ex_alu_op=10, ex_dst=3, ex_rd1=5, ex_rd2=7, ex_funct=0x20.
- lw sign extension: lw $4,-4($1) (0x8C24FFFC) -> ex_mem_read=1, ex_alu_src=1, ex_dst=4, ex_imm=0xFFFFFFFC.
- Load-use: lw $4,0($1), then add $5,$4,$2 -> stall_out=1 for exactly one cycle, then one bubble (ex_valid=0, ex_reg_write=0), then add with ex_rs=4. Same sequence with lw $0: no stall.
- Flush priority: flush=1 together with hold_in=1 and a valid instruction -> next cycle ex_valid=0, all control 0, stall_out=1 during that cycle (hold_in).
- Illegal opcode: 0xFC000000 -> ex_valid=1, ex_illegal=1, all other control 0.
